mux2to1: RTL and testbench



---
 rtl/mux2to1_pkg.sv | 8 +
 rtl/mux2to1_comb.sv | 16 +
 rtl/mux2to1.sv | 52 +++++
 tb/tb_mux2to1.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/mux2to1_pkg.sv
// Shared constants for the 2:1 operand/result multiplexer.
// The default data width tracks the ALU datapath width.
package mux2to1_pkg;

   localparam int unsigned ALU_DATA_WIDTH = 32;
   localparam int unsigned MAX_DATA_WIDTH = 64;

endpackage : mux2to1_pkg

// File: rtl/mux2to1_comb.sv
// Pure combinational 2:1 selector: mux_out = s ? i1 : i0, bit-exact.
// The ternary form keeps an unknown select visible in simulation instead of defaulting to i0.
module mux2to1_comb
   import mux2to1_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = ALU_DATA_WIDTH
) (
   input  logic                  s,
   input  logic [DATA_WIDTH-1:0] i0,
   input  logic [DATA_WIDTH-1:0] i1,
   output logic [DATA_WIDTH-1:0] mux_out
);

   assign mux_out = s ? i1 : i0;

endmodule : mux2to1_comb

// File: rtl/mux2to1.sv
// 2:1 data multiplexer with a combinational output, a one-cycle registered copy,
// a registered select and a select-change flag. Single clock, synchronous active-high reset.
module mux2to1
   import mux2to1_pkg::*;
#(
   parameter int unsigned          DATA_WIDTH  = ALU_DATA_WIDTH,
   parameter logic [DATA_WIDTH-1:0] RESET_VALUE = {DATA_WIDTH{1'b0}}
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  s,
   input  logic [DATA_WIDTH-1:0] i0,
   input  logic [DATA_WIDTH-1:0] i1,
   output logic [DATA_WIDTH-1:0] mux_out,
   output logic [DATA_WIDTH-1:0] mux_out_q,
   output logic                  sel_q,
   output logic                  sel_changed
);

   logic [DATA_WIDTH-1:0] w_mux_out;
   logic [DATA_WIDTH-1:0] r_mux_out_q;
   logic                  r_sel_q;
   logic                  r_sel_changed;

   mux2to1_comb #(
      .DATA_WIDTH (DATA_WIDTH)
   ) u_comb (
      .s       (s),
      .i0      (i0),
      .i1      (i1),
      .mux_out (w_mux_out)
   );

   // Capture selection, select and select-change; reset wins over any input activity.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_mux_out_q   <= RESET_VALUE;
         r_sel_q       <= 1'b0;
         r_sel_changed <= 1'b0;
      end else begin
         r_mux_out_q   <= w_mux_out;
         r_sel_q       <= s;
         r_sel_changed <= (s != r_sel_q);
      end
   end

   assign mux_out     = w_mux_out;
   assign mux_out_q   = r_mux_out_q;
   assign sel_q       = r_sel_q;
   assign sel_changed = r_sel_changed;

endmodule : mux2to1

// File: tb/tb_mux2to1.sv
// Directed, table-driven bench for mux2to1: a 32-bit instance with a non-zero reset
// value and a 1-bit instance for exhaustive selection.
module tb_mux2to1;

   logic        clk = 1'b0;
   logic        rst;
   logic        s;
   logic [31:0] i0;
   logic [31:0] i1;
   logic [31:0] mux_out;
   logic [31:0] mux_out_q;
   logic        sel_q;
   logic        sel_changed;

   logic        s_n;
   logic        i0_n;
   logic        i1_n;
   logic        mux_out_n;
   logic        mux_out_q_n;
   logic        sel_q_n;
   logic        sel_changed_n;

   int n_tests = 0;
   int n_fail  = 0;

   typedef struct {
      logic        s;
      logic [31:0] i0;
      logic [31:0] i1;
      logic [31:0] exp;
   } vec_t;

   vec_t vecs[16];
   vec_t vecs1[8];

   always #5 clk = ~clk;

   mux2to1 #(
      .DATA_WIDTH  (32),
      .RESET_VALUE (32'hDEADBEEF)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .s           (s),
      .i0          (i0),
      .i1          (i1),
      .mux_out     (mux_out),
      .mux_out_q   (mux_out_q),
      .sel_q       (sel_q),
      .sel_changed (sel_changed)
   );

   mux2to1 #(
      .DATA_WIDTH  (1),
      .RESET_VALUE (1'b1)
   ) dut_n (
      .clk         (clk),
      .rst         (rst),
      .s           (s_n),
      .i0          (i0_n),
      .i1          (i1_n),
      .mux_out     (mux_out_n),
      .mux_out_q   (mux_out_q_n),
      .sel_q       (sel_q_n),
      .sel_changed (sel_changed_n)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic prev_s;

      // Combinational table: 10 alternating steps of 1 / -1, then assorted patterns.
      for (int k = 0; k < 10; k++) begin
         vecs[k].s   = k[0];
         vecs[k].i0  = 32'h0000_0001;
         vecs[k].i1  = 32'hFFFF_FFFF;
         vecs[k].exp = k[0] ? 32'hFFFF_FFFF : 32'h0000_0001;
      end
      vecs[10] = '{1'b0, 32'hA5A5_A5A5, 32'h5A5A_5A5A, 32'hA5A5_A5A5};
      vecs[11] = '{1'b1, 32'hA5A5_A5A5, 32'h5A5A_5A5A, 32'h5A5A_5A5A};
      vecs[12] = '{1'b0, 32'h8000_0000, 32'h7FFF_FFFF, 32'h8000_0000};
      vecs[13] = '{1'b1, 32'h8000_0000, 32'h7FFF_FFFF, 32'h7FFF_FFFF};
      vecs[14] = '{1'b1, 32'h0000_0000, 32'h1234_5678, 32'h1234_5678};
      vecs[15] = '{1'b0, 32'hCAFE_F00D, 32'h0000_0000, 32'hCAFE_F00D};

      for (int k = 0; k < 8; k++) begin
         vecs1[k].s   = k[2];
         vecs1[k].i0  = {31'd0, k[1]};
         vecs1[k].i1  = {31'd0, k[0]};
         vecs1[k].exp = k[2] ? {31'd0, k[0]} : {31'd0, k[1]};
      end

      rst  = 1'b1;
      s    = 1'b0;
      i0   = 32'h0000_0001;
      i1   = 32'hFFFF_FFFF;
      s_n  = 1'b0;
      i0_n = 1'b0;
      i1_n = 1'b0;

      // Combinational path, stepped every 10 ns independent of clock phase.
      #3;
      for (int k = 0; k < 16; k++) begin
         s  = vecs[k].s;
         i0 = vecs[k].i0;
         i1 = vecs[k].i1;
         #10;
         check($sformatf("comb_vec%0d", k), {32'd0, mux_out}, {32'd0, vecs[k].exp});
      end

      // Two reset cycles, s low.
      s  = 1'b0;
      i0 = 32'h0000_0001;
      i1 = 32'hFFFF_FFFF;
      tick();
      tick();
      check("rst_mux_out_q", {32'd0, mux_out_q}, {32'd0, 32'hDEADBEEF});
      check("rst_sel_q", {63'd0, sel_q}, 64'd0);
      check("rst_sel_changed", {63'd0, sel_changed}, 64'd0);
      check("rst_mux_out_q_w1", {63'd0, mux_out_q_n}, 64'd1);

      // s=1 during reset: mux_out tracks, state stays cleared.
      s = 1'b1;
      #1;
      check("rst_comb_tracks", {32'd0, mux_out}, {32'd0, 32'hFFFF_FFFF});
      tick();
      check("rst_hold_sel_q", {63'd0, sel_q}, 64'd0);
      check("rst_hold_mux_out_q", {32'd0, mux_out_q}, {32'd0, 32'hDEADBEEF});

      // First edge after reset with s=1 flags a change.
      rst = 1'b0;
      tick();
      check("post_rst_sel_changed", {63'd0, sel_changed}, 64'd1);
      check("post_rst_sel_q", {63'd0, sel_q}, 64'd1);
      check("post_rst_mux_out_q", {32'd0, mux_out_q}, {32'd0, 32'hFFFF_FFFF});

      // Hold s=1 for two more cycles, then drop to 0.
      tick();
      check("hold1_sel_changed", {63'd0, sel_changed}, 64'd0);
      tick();
      check("hold2_sel_changed", {63'd0, sel_changed}, 64'd0);
      s = 1'b0;
      #1;
      check("fall_comb", {32'd0, mux_out}, {32'd0, 32'h0000_0001});
      check("fall_lag", {32'd0, mux_out_q}, {32'd0, 32'hFFFF_FFFF});
      tick();
      check("fall_mux_out_q", {32'd0, mux_out_q}, {32'd0, 32'h0000_0001});
      check("fall_sel_changed", {63'd0, sel_changed}, 64'd1);
      tick();
      check("fall_pulse_end", {63'd0, sel_changed}, 64'd0);

      // Toggle every clock for 8 cycles.
      prev_s = 1'b0;
      for (int k = 0; k < 8; k++) begin
         s = ~prev_s;
         prev_s = s;
         tick();
         check($sformatf("tog%0d_sel_changed", k), {63'd0, sel_changed}, 64'd1);
         check($sformatf("tog%0d_sel_q", k), {63'd0, sel_q}, {63'd0, prev_s});
         check($sformatf("tog%0d_mux_out_q", k), {32'd0, mux_out_q},
               {32'd0, (prev_s ? 32'hFFFF_FFFF : 32'h0000_0001)});
      end

      // Reset mid-stream with s held high, then resume with s=0.
      s   = 1'b1;
      rst = 1'b1;
      tick();
      check("mid_rst_mux_out_q", {32'd0, mux_out_q}, {32'd0, 32'hDEADBEEF});
      check("mid_rst_sel_q", {63'd0, sel_q}, 64'd0);
      check("mid_rst_sel_changed", {63'd0, sel_changed}, 64'd0);
      rst = 1'b0;
      s   = 1'b0;
      i0  = 32'h0BAD_CAFE;
      tick();
      check("mid_resume_sel_changed", {63'd0, sel_changed}, 64'd0);
      check("mid_resume_mux_out_q", {32'd0, mux_out_q}, {32'd0, 32'h0BAD_CAFE});

      // 1-bit instance: exhaustive combinational selection.
      for (int k = 0; k < 8; k++) begin
         s_n  = vecs1[k].s;
         i0_n = vecs1[k].i0[0];
         i1_n = vecs1[k].i1[0];
         #1;
         check($sformatf("w1_vec%0d", k), {63'd0, mux_out_n}, {32'd0, vecs1[k].exp});
      end
      tick();
      check("w1_mux_out_q", {63'd0, mux_out_q_n}, 64'd1);
      check("w1_sel_q", {63'd0, sel_q_n}, 64'd1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule : tb_mux2to1
